// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM state type and word width
// shared by dmem_lsu and its lane-steering helper dmem_align.
package dmem_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane steering for dmem_lsu.
// in: we, funct3, off (addr[1:0]), wdata, rword (array word)
// out: be/wword (store lanes), ldata (formatted load), err.
// `define DMEM_MISALIGN_TRAP_EN to flag misaligned H/W accesses;
// otherwise low address bits are dropped to natural alignment.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic              we,
  input  logic [1:0]        off,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rword,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wword,
  output logic [WORD_W-1:0] ldata,
  output logic              err
);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        ill;
  logic        mis;
  logic [7:0]  byt;
  logic [15:0] hw;

  // Halves pick by off[1] only, which is the forced
  // alignment when misalignment is not trapped.
  assign byt = rword[{off, 3'b000} +: 8];
  assign hw  = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ill   = 1'b0;
    mis   = 1'b0;
    be    = '0;
    wword = '0;
    ldata = '0;
    if (we) begin
      unique case (funct3)
        SB: begin
          be    = 4'b0001 << off;
          wword = {4{wdata[7:0]}};
        end
        SH: begin
          mis   = off[0];
          be    = off[1] ? 4'b1100 : 4'b0011;
          wword = {2{wdata[15:0]}};
        end
        SW: begin
          mis   = |off;
          be    = 4'b1111;
          wword = wdata;
        end
        default: ill = 1'b1;
      endcase
    end else begin
      unique case (funct3)
        LB:  ldata = {{24{byt[7]}}, byt};
        LBU: ldata = {24'b0, byt};
        LH: begin
          mis   = off[0];
          ldata = {{16{hw[15]}}, hw};
        end
        LHU: begin
          mis   = off[0];
          ldata = {16'b0, hw};
        end
        LW: begin
          mis   = |off;
          ldata = rword;
        end
        default: ill = 1'b1;
      endcase
    end
    err = ill | (TRAP & mis);
    if (err) begin
      be    = '0;
      ldata = '0;
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-array data memory with load/store unit.
// req_*: valid/ready request (we, addr, wdata, funct3);
// rsp_*: 1-cycle strobe with formatted rdata and err.
// Params ADDR_W (byte addr width), WAIT_STATES (0..7).
// Misalign handling follows DMEM_MISALIGN_TRAP_EN (dmem_align).
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

  state_t state;
  state_t nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;

  logic              q_we;
  logic [ADDR_W-1:0] q_addr;
  logic [31:0]       q_wdata;
  logic [2:0]        q_f3;

  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata;
  logic [2:0]        e_f3;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] idx;
  logic [WORD_W-1:0] rword;
  logic [3:0]        be;
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] ldata;
  logic              err;

  logic accept;
  logic go_resp;
  logic commit;
  logic [31:0] rdata_q;
  logic        err_q;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_ready & req_valid;

  // With no wait states the access happens on the accept
  // edge itself, so the live request is used in IDLE.
  assign e_we    = req_ready ? req_we     : q_we;
  assign e_addr  = req_ready ? req_addr   : q_addr;
  assign e_wdata = req_ready ? req_wdata  : q_wdata;
  assign e_f3    = req_ready ? req_funct3 : q_f3;

  assign idx    = e_addr[ADDR_W-1:2];
  assign rword  = mem[idx];
  // The array has no reset, so block writes while reset is high.
  assign commit = go_resp & ~reset;

  dmem_align u_align (
    .funct3 (e_f3),
    .we     (e_we),
    .off    (e_addr[1:0]),
    .wdata  (e_wdata),
    .rword  (rword),
    .be     (be),
    .wword  (wword),
    .ldata  (ldata),
    .err    (err)
  );

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    go_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            nxt     = RESP;
            go_resp = 1'b1;
          end else begin
            nxt     = WAIT;
            cnt_nxt = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == WS_LAST) begin
          nxt     = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_f3    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        q_we    <= req_we;
        q_addr  <= req_addr;
        q_wdata <= req_wdata;
        q_f3    <= req_funct3;
      end
      if (go_resp) begin
        rdata_q <= e_we ? '0 : ldata;
        err_q   <= err;
      end else if (state == RESP) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && e_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

endmodule
